// File: rtl/fetch_pkg.sv
// Shared types, defaults and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_W          = 16;
  localparam int unsigned DEF_PC_STEP      = 2;
  localparam int unsigned DEF_RESET_PC     = 0;
  localparam logic [3:0]  DEF_HALT_OPCODE  = 4'hF;

  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [FETCH_W-1:0] pc_next;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [3:0] opcode, input logic [3:0] halt_op);
    return opcode == halt_op;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; clear discards contents after any same-cycle pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: credit-limited pipelined requests into a prefetch queue,
// with redirect flush and halt freeze.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      DATA_W      = FETCH_W,
  parameter int unsigned      DEPTH       = 4,
  parameter int unsigned      PC_STEP     = DEF_PC_STEP,
  parameter int unsigned      RESET_PC    = DEF_RESET_PC,
  parameter logic [3:0]       HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_en,
  input  logic [DATA_W-1:0] branch_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc_next,
  output logic              halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_next;
  } entry_t;

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              halt_seen_q, halt_seen_d;

  logic              credit_ok;
  logic              grant;
  logic              resp_drop;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;
  logic [CW-1:0]     count;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    halt_seen_d   = halt_seen_q;

    // Queued plus in-flight words never exceed DEPTH, so every response has a slot.
    credit_ok     = ((CW+1)'(count) + (CW+1)'(outstanding_q)) < (CW+1)'(DEPTH);
    imem_req      = !rst && !branch_en && !halt_seen_q && credit_ok;
    imem_addr     = fetch_pc_q;
    grant         = imem_req && imem_gnt;
    pop           = instr_valid && instr_ready;
    resp_drop     = imem_rvalid && (branch_en || (drop_cnt_q != '0));
    push          = imem_rvalid && !resp_drop;
    push_data     = '{instr: imem_rdata, pc_next: resp_pc_q + DATA_W'(PC_STEP)};
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);

    if (branch_en) begin
      fetch_pc_d  = branch_pc;
      resp_pc_d   = branch_pc;
      halt_seen_d = 1'b0;
      drop_cnt_d  = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + DATA_W'(PC_STEP);
      end
      if (imem_rvalid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = push_data.pc_next;
        // Everything still in flight behind a halt word is stale.
        if (is_halt(imem_rdata[DATA_W-1 -: 4], HALT_OPCODE)) begin
          halt_seen_d = 1'b1;
          drop_cnt_d  = outstanding_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= DATA_W'(RESET_PC);
      resp_pc_q     <= DATA_W'(RESET_PC);
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      halt_seen_q   <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halt_seen_q   <= halt_seen_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (branch_en),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign pc_next     = head.pc_next;
  assign halted      = halt_seen_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with a fixed-latency in-order memory model.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_en;
  logic [15:0] branch_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] pc_next;
  logic        halted;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          lat    = 1;
  logic [15:0] halt_addr = 16'hFFFF;

  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] grants[$];
  logic [15:0] dlv_instr[$];
  logic [15:0] dlv_pc[$];

  logic        last_req;
  logic [15:0] last_addr;
  logic        last_grant;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .branch_en   (branch_en),
    .branch_pc   (branch_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_next     (pc_next),
    .halted      (halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: entered and left at a falling edge.
  task automatic tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    #1;
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_grant = imem_req & imem_gnt;
    if (instr_valid && instr_ready && !rst) begin
      dlv_instr.push_back(instr);
      dlv_pc.push_back(pc_next);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (last_grant) begin
      grants.push_back(last_addr);
      pend_addr.push_back(last_addr);
      pend_due.push_back(cyc + lat);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    branch_en = 1'b0;
    tick();
    rst = 1'b0;
    grants.delete();
    dlv_instr.delete();
    dlv_pc.delete();
  endtask

  initial begin
    rst         = 1'b1;
    branch_en   = 1'b0;
    branch_pc   = '0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b1;
    @(negedge clk);

    // Reset values
    tick();
    chk("rst_req",   32'(imem_req),    0);
    chk("rst_addr",  32'(imem_addr),   0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr),       0);
    chk("rst_pcn",   32'(pc_next),     0);
    chk("rst_halt",  32'(halted),      0);

    // Streaming, L=1
    do_reset();
    lat = 1; imem_gnt = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stream_req",   32'(last_req),    1);
      chk("stream_addr",  32'(last_addr),   32'(2 * i));
      chk("stream_valid", 32'(instr_valid), 32'(i >= 1));
      if (i >= 1) begin
        chk("stream_pcn",   32'(pc_next), 32'(2 * i));
        chk("stream_instr", 32'(instr),   32'(16'h1000 + 2 * (i - 1)));
      end
    end

    // Backpressure
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_req", 32'(last_req), 32'(i < 4));
    end
    chk("bp_valid", 32'(instr_valid), 1);
    chk("bp_head",  32'(pc_next),     32'h2);
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_ndlv", 32'(dlv_instr.size() >= 5), 1);
    if (dlv_instr.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("bp_dlv_instr", 32'(dlv_instr[k]), 32'(16'h1000 + 2 * k));
        chk("bp_dlv_pcn",   32'(dlv_pc[k]),    32'(2 * k + 2));
      end
    end
    chk("bp_ngrant", 32'(grants.size() >= 5), 1);
    if (grants.size() >= 5) chk("bp_resume", 32'(grants[4]), 32'h8);

    // Redirect with two requests in flight, L=3
    do_reset();
    lat = 3;
    tick();
    tick();
    branch_en = 1'b1; branch_pc = 16'h0040;
    tick();
    chk("br_req", 32'(last_req), 0);
    chk("br_empty", 32'(instr_valid), 0);
    branch_en = 1'b0;
    for (int i = 3; i < 6; i++) begin
      tick();
      if (i == 3) chk("br_target", 32'(last_addr), 32'h40);
      chk("br_drop", 32'(instr_valid), 0);
    end
    tick();
    chk("br_valid", 32'(instr_valid), 1);
    chk("br_pcn",   32'(pc_next),     32'h42);
    chk("br_instr", 32'(instr),       32'h1040);

    // Halt word from 0x0006
    do_reset();
    lat = 1; halt_addr = 16'h0006;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) chk("halt_early", 32'(halted), 0);
    end
    chk("halt_set",   32'(halted),  1);
    chk("halt_instr", 32'(instr),   32'hF000);
    chk("halt_pcn",   32'(pc_next), 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_noreq", 32'(last_req), 0);
    end
    chk("halt_ndlv",  32'(dlv_instr.size()), 4);
    chk("halt_empty", 32'(instr_valid), 0);
    branch_en = 1'b1; branch_pc = 16'h0010;
    tick();
    branch_en = 1'b0;
    halt_addr = 16'hFFFF;
    chk("halt_clear", 32'(halted), 0);
    tick();
    chk("halt_rreq",  32'(last_req),  1);
    chk("halt_raddr", 32'(last_addr), 32'h10);
    tick();
    chk("halt_rpcn",   32'(pc_next), 32'h12);
    chk("halt_rinstr", 32'(instr),   32'h1010);

    // Grant stall
    do_reset();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req",  32'(last_req),  1);
      chk("stall_addr", 32'(last_addr), 0);
    end
    imem_gnt = 1'b1;
    tick();
    chk("stall_gaddr", 32'(last_addr), 0);
    tick();
    chk("stall_next", 32'(last_addr), 32'h2);

    // Reset mid-stream with queued and in-flight words
    do_reset();
    lat = 3; instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_full", 32'(instr_valid), 1);
    rst = 1'b1;
    tick();
    chk("mid_req",   32'(imem_req),    0);
    chk("mid_addr",  32'(imem_addr),   0);
    chk("mid_valid", 32'(instr_valid), 0);
    chk("mid_instr", 32'(instr),       0);
    chk("mid_pcn",   32'(pc_next),     0);
    chk("mid_halt",  32'(halted),      0);
    rst = 1'b0; lat = 1; instr_ready = 1'b1;
    grants.delete(); dlv_instr.delete(); dlv_pc.delete();
    tick();
    chk("mid_rreq",  32'(last_req),  1);
    chk("mid_raddr", 32'(last_addr), 0);
    tick();
    chk("mid_rpcn",   32'(pc_next), 32'h2);
    chk("mid_rinstr", 32'(instr),   32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
